// File: rtl/n101_icb_rd_pkg.sv
// Shared constants for the ICB burst reader: FSM state encodings and bus word geometry.
package n101_icb_rd_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  localparam int BUS_DW     = 32;
  localparam int WORD_BYTES = BUS_DW / 8;
  localparam int WORD_LSB   = $clog2(WORD_BYTES);

endpackage

// File: rtl/n101_icb_rd_fifo.sv
// Response buffer for the ICB burst reader. Power-of-two depth, push and pop
// may coincide in any fill state; a push into a full FIFO is only taken when a
// pop frees the slot in the same cycle.
module n101_icb_rd_fifo
  import n101_icb_rd_pkg::*;
#(
  parameter int DW    = BUS_DW,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DW-1:0]                wdata,
  input  logic                         pop,
  output logic [DW-1:0]                rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [NW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign do_pop_s  = pop & (count_r != '0);
  assign do_push_s = push & ((count_r != NW'(DEPTH)) | do_pop_s);

  assign rdata = mem_r[rd_ptr_r];
  assign full  = (count_r == NW'(DEPTH));
  assign empty = (count_r == '0);
  assign count = count_r;

  // Storage array: written on every accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + NW'(1);
        2'b01:   count_r <= count_r - NW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/n101_icb_burst_reader.sv
// ICB burst read initiator: fetches word_cnt consecutive words starting at
// start_addr and streams them out in address order. Commands are only issued
// when the response FIFO has room for every read in flight, so rsp_ready can
// stay tied high. Optional build macro N101_BURST_RD_ERR_ABORT_EN stops issuing
// after the first error response.
module n101_icb_burst_reader
  import n101_icb_rd_pkg::*;
#(
  parameter int AW   = 12,
  parameter int DW   = BUS_DW,
  parameter int OUTS = 2,
  parameter int CW   = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [CW-1:0] word_cnt,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          icb_cmd_valid,
  input  logic          icb_cmd_ready,
  output logic [AW-1:0] icb_cmd_addr,
  output logic          icb_cmd_read,
  input  logic          icb_rsp_valid,
  output logic          icb_rsp_ready,
  input  logic          icb_rsp_err,
  input  logic [DW-1:0] icb_rsp_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  localparam int            OW     = $clog2(OUTS + 1);
  localparam logic [AW-1:0] STRIDE = AW'(WORD_BYTES);

  logic [1:0]    state_r;
  logic [AW-1:0] addr_r;
  logic [CW-1:0] remain_r;
  logic [OW-1:0] outst_r;
  logic          busy_r;
  logic          done_r;
  logic          err_r;
  logic          cmd_valid_r;

  logic          cmd_hs_s;
  logic          rsp_acc_s;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic [OW-1:0] count_s;
  logic [OW-1:0] outst_nxt_s;
  logic [OW-1:0] count_nxt_s;
  logic [DW-1:0] fifo_rdata_s;
  logic          credit_ok_s;
  logic          last_hs_s;
  logic          abort_s;

  assign cmd_hs_s  = cmd_valid_r & icb_cmd_ready;
  // A response is only legitimate if a read is in flight or issued this cycle.
  assign rsp_acc_s = icb_rsp_valid & ((outst_r != '0) | cmd_hs_s);
  assign pop_s     = ~empty_s & out_ready;
  assign push_s    = rsp_acc_s & (~full_s | pop_s);
  assign last_hs_s = cmd_hs_s & (remain_r == CW'(1));

`ifdef N101_BURST_RD_ERR_ABORT_EN
  assign abort_s = err_r | (rsp_acc_s & icb_rsp_err);
`else
  assign abort_s = 1'b0;
`endif

  // Look-ahead occupancy: credit and drain decisions use end-of-cycle values.
  always_comb begin
    outst_nxt_s = outst_r;
    count_nxt_s = count_s;
    if (cmd_hs_s & ~rsp_acc_s) begin
      outst_nxt_s = outst_r + OW'(1);
    end else if (~cmd_hs_s & rsp_acc_s) begin
      outst_nxt_s = outst_r - OW'(1);
    end else begin
      outst_nxt_s = outst_r;
    end
    if (push_s & ~pop_s) begin
      count_nxt_s = count_s + OW'(1);
    end else if (~push_s & pop_s) begin
      count_nxt_s = count_s - OW'(1);
    end else begin
      count_nxt_s = count_s;
    end
  end

  assign credit_ok_s = ({1'b0, outst_nxt_s} + {1'b0, count_nxt_s}) < (OW + 1)'(OUTS);

  // Transfer control FSM with its registered status and command outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      addr_r      <= '0;
      remain_r    <= '0;
      outst_r     <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      cmd_valid_r <= 1'b0;
    end else begin
      outst_r <= outst_nxt_s;
      if (rsp_acc_s) begin
        err_r <= err_r | icb_rsp_err;
      end
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            addr_r   <= {start_addr[AW-1:WORD_LSB], {WORD_LSB{1'b0}}};
            remain_r <= word_cnt;
            err_r    <= 1'b0;
            busy_r   <= 1'b1;
            if (word_cnt == '0) begin
              state_r <= ST_FIN;
              done_r  <= 1'b1;
            end else begin
              state_r     <= ST_ISSUE;
              cmd_valid_r <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (cmd_hs_s) begin
            addr_r   <= addr_r + STRIDE;
            remain_r <= remain_r - CW'(1);
          end
          if (cmd_valid_r & ~icb_cmd_ready) begin
            cmd_valid_r <= 1'b1;
          end else if (last_hs_s | abort_s) begin
            cmd_valid_r <= 1'b0;
            state_r     <= ST_DRAIN;
          end else begin
            cmd_valid_r <= credit_ok_s;
          end
        end
        ST_DRAIN: begin
          if ((outst_nxt_s == '0) && (count_nxt_s == '0)) begin
            state_r <= ST_FIN;
            done_r  <= 1'b1;
          end
        end
        ST_FIN: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          cmd_valid_r <= 1'b0;
        end
      endcase
    end
  end

  n101_icb_rd_fifo #(
    .DW    (DW),
    .DEPTH (OUTS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .wdata (icb_rsp_rdata),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;
  assign icb_cmd_valid = cmd_valid_r;
  assign icb_cmd_addr  = addr_r;
  assign icb_cmd_read  = 1'b1;
  assign icb_rsp_ready = 1'b1;
  assign out_valid     = ~empty_s;
  assign out_data      = empty_s ? '0 : fifo_rdata_s;

endmodule

// File: tb/tb_n101_icb_burst_reader.sv
// Scoreboard bench for n101_icb_burst_reader. A behavioural ICB target with
// configurable latency and ready patterns serves a synthetic ROM; expected
// addresses and words are computed from start address and count when each
// transfer is launched, and a monitor process pops them as the DUT presents
// commands and stream words. Honors N101_BURST_RD_ERR_ABORT_EN if defined.
module tb_n101_icb_burst_reader;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int OUTS = 2;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [CW-1:0] word_cnt;
  logic          busy, done, err;
  logic          icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
  logic [AW-1:0] icb_cmd_addr;
  logic          icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
  logic [DW-1:0] icb_rsp_rdata;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;

  int vectors = 0;
  int miscompares = 0;

  // target / consumer configuration
  int lat = 0;
  int cmd_mode = 0;
  int out_mode = 0;
  int err_idx = -1;

  // run bookkeeping
  int cyc = 0;
  int cmd_cnt = 0;
  int outst_tb = 0;
  int delivered = 0;
  int first_out = -1;
  int start_cyc = 0;
  int done_cyc = 0;
  bit done_seen = 1'b0;
  logic done_err = 1'b0;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic          e;
  } rsp_t;

  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  rsp_t          pend_q[$];

  always #5 clk = ~clk;

  n101_icb_burst_reader #(.AW(AW), .DW(DW), .OUTS(OUTS), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .word_cnt(word_cnt),
    .busy(busy), .done(done), .err(err),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_addr(icb_cmd_addr),
    .icb_cmd_read(icb_cmd_read), .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_err(icb_rsp_err), .icb_rsp_rdata(icb_rsp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {8'hC3, a, ~a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Target model, stream consumer and monitor, all acting mid-cycle.
  initial begin
    logic          prev_wait;
    logic [AW-1:0] prev_addr;
    rsp_t          r;
    prev_wait = 1'b0;
    prev_addr = '0;
    icb_cmd_ready = 1'b0;
    icb_rsp_valid = 1'b0;
    icb_rsp_err = 1'b0;
    icb_rsp_rdata = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (cmd_mode)
        0:       icb_cmd_ready = 1'b1;
        1:       icb_cmd_ready = cyc[0];
        default: icb_cmd_ready = 1'($urandom_range(0, 1));
      endcase
      case (out_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (!rst && prev_wait) begin
        check("cmd_hold_valid", icb_cmd_valid, 1);
        check("cmd_hold_addr", icb_cmd_addr, prev_addr);
      end
      prev_wait = !rst && icb_cmd_valid && !icb_cmd_ready;
      prev_addr = icb_cmd_addr;
      if (!rst && icb_cmd_valid && icb_cmd_ready) begin
        if (exp_addr_q.size() == 0) check("cmd_extra", 1, 0);
        else check("cmd_addr", icb_cmd_addr, exp_addr_q.pop_front());
        pend_q.push_back('{cyc + lat, icb_cmd_addr, (cmd_cnt == err_idx)});
        cmd_cnt++;
        outst_tb++;
      end
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        r = pend_q.pop_front();
        icb_rsp_valid = 1'b1;
        icb_rsp_rdata = rom_word(r.addr);
        icb_rsp_err = r.e;
        check("rsp_ready", icb_rsp_ready, 1);
        if (!rst) outst_tb--;
      end else begin
        icb_rsp_valid = 1'b0;
        icb_rsp_err = 1'b0;
        icb_rsp_rdata = '0;
      end
      if (!rst && icb_cmd_valid && icb_cmd_ready) check("outstanding_max", (outst_tb <= OUTS), 1);
      if (!rst && out_valid && out_ready) begin
        if (first_out < 0) first_out = cyc;
        if (exp_data_q.size() == 0) check("out_extra", 1, 0);
        else check("out_data", out_data, exp_data_q.pop_front());
        delivered++;
      end
      if (!rst && done && !done_seen) begin
        done_seen = 1'b1;
        done_cyc = cyc;
        done_err = err;
      end
    end
  end

  task automatic check_reset_values();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cmd_valid", icb_cmd_valid, 0);
    check("rst_cmd_addr", icb_cmd_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_rsp_ready", icb_rsp_ready, 1);
    check("rst_cmd_read", icb_cmd_read, 1);
  endtask

  task automatic run_xfer(input logic [AW-1:0] addr, input int cnt, input int l, input int cm,
                          input int om, input int eidx, input bit stall, input bit poke,
                          input int exp_done);
    logic [AW-1:0] a;
    bit exp_err;
    lat = l; cmd_mode = cm; out_mode = stall ? 1 : om; err_idx = eidx;
    cmd_cnt = 0; outst_tb = 0; delivered = 0; first_out = -1; done_seen = 1'b0;
    exp_addr_q.delete(); exp_data_q.delete();
    a = {addr[AW-1:2], 2'b00};
    for (int i = 0; i < cnt; i++) begin
      exp_addr_q.push_back(a);
      exp_data_q.push_back(rom_word(a));
      a = a + 12'd4;
    end
    exp_err = (eidx >= 0) && (eidx < cnt);
    @(negedge clk);
    start = 1'b1; start_addr = addr; word_cnt = CW'(cnt); start_cyc = cyc;
    @(negedge clk);
    start = 1'b0; start_addr = 12'($urandom); word_cnt = 10'($urandom);
    check("busy_at_n1", busy, 1);
    if (cnt == 0) check("done_at_n1", done, 1);
    else check("cmd_valid_at_n1", icb_cmd_valid, 1);
    if (poke) begin
      @(negedge clk);
      start = 1'b1; start_addr = 12'h800; word_cnt = 10'd3;
      @(negedge clk);
      start = 1'b0;
    end
    if (stall) begin
      repeat (20) @(negedge clk);
      check("stall_cmds", cmd_cnt, OUTS);
      check("stall_cmd_valid", icb_cmd_valid, 0);
      check("stall_no_words", delivered, 0);
      out_mode = om;
    end
    for (int k = 0; k < 3000 && !done_seen; k++) @(posedge clk);
    check("done_seen", done_seen, 1);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
    check("err_at_done", done_err, exp_err);
    if (exp_done >= 0) check("done_latency", done_cyc - start_cyc, exp_done);
    if (exp_done >= 0 && cnt > 0) check("first_word_latency", first_out - start_cyc, 2);
    if (cnt == 0) check("zero_cnt_cmds", cmd_cnt, 0);
`ifdef N101_BURST_RD_ERR_ABORT_EN
    if (exp_err) begin
      check("abort_word_bound", (delivered <= eidx + 1 + OUTS), 1);
    end else begin
      check("word_count", delivered, cnt);
    end
`else
    check("word_count", delivered, cnt);
    check("scoreboard_empty", exp_data_q.size(), 0);
`endif
    exp_addr_q.delete(); exp_data_q.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = '0; word_cnt = '0;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic burst, zero-latency ROM, consumer always ready
    run_xfer(12'h104, 4, 0, 0, 0, -1, 1'b0, 1'b0, 6);
    // address wrap past the top of the AW space
    run_xfer(12'hFF8, 4, 0, 0, 0, -1, 1'b0, 1'b0, 6);
    // unaligned start is rounded down
    run_xfer(12'h2A7, 3, 0, 0, 0, -1, 1'b0, 1'b0, -1);
    // consumer stalled: credit caps issued reads, then everything drains
    run_xfer(12'h040, 8, 0, 0, 0, -1, 1'b1, 1'b0, -1);
    // slow target with toggling cmd_ready, random consumer
    run_xfer(12'h300, 10, 3, 1, 2, -1, 1'b0, 1'b0, -1);
    // error response on word 2 of 5
    run_xfer(12'h500, 5, 0, 0, 0, 2, 1'b0, 1'b0, -1);
    run_xfer(12'h600, 5, 2, 1, 2, 2, 1'b0, 1'b0, -1);
    // start while busy is ignored
    run_xfer(12'h700, 6, 2, 0, 2, -1, 1'b0, 1'b1, -1);
    // zero-length request
    run_xfer(12'h123, 0, 0, 0, 0, -1, 1'b0, 1'b0, 1);

    // randomized transfers
    for (int t = 0; t < 12; t++) begin
      int c;
      int e;
      c = $urandom_range(1, 12);
      e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, c - 1)) : -1;
      run_xfer(12'($urandom), c, $urandom_range(0, 3), $urandom_range(0, 2),
               ($urandom_range(0, 1) == 0) ? 0 : 2, e, 1'b0, 1'b0, -1);
    end

    // reset mid-ISSUE with two reads in flight
    lat = 3; cmd_mode = 0; out_mode = 1; err_idx = -1;
    cmd_cnt = 0; outst_tb = 0; done_seen = 1'b0;
    exp_addr_q.delete(); exp_data_q.delete();
    for (int i = 0; i < 8; i++) exp_addr_q.push_back(12'h380 + 12'(4 * i));
    @(negedge clk);
    start = 1'b1; start_addr = 12'h380; word_cnt = 10'd8;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10 && outst_tb < 2; k++) @(posedge clk);
    check("rst_test_outstanding", outst_tb, 2);
    #2 rst = 1'b1;
    #1 check_reset_values();
    exp_addr_q.delete(); exp_data_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_busy", busy, 0);
    run_xfer(12'h040, 1, 0, 0, 0, -1, 1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/n101_icb_burst_reader.md
# n101_icb_burst_reader

ICB read initiator that fetches a block of consecutive words from an ICB memory target (e.g. the mask ROM) and presents them as a valid/ready word stream. It sits between a boot or copy controller, which supplies a start address and word count, and any ICB target bus port. It keeps up to OUTS reads in flight and buffers responses so the target never sees rsp_ready deasserted.

## Interface
- AW, 12, ICB byte-address width
- DW, 32, data width; address stride is DW/8 bytes
- OUTS, 2, FIFO depth and maximum outstanding reads (power of two, ≥2)
- CW, 10, word-count width
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- start_addr  in  AW  first byte address; low log2(DW/8) bits forced to 0
- word_cnt  in  CW  number of words to read
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error of the finished transfer; valid with done, held until next start
- icb_cmd_valid  out  1  command valid
- icb_cmd_ready  in  1  command ready
- icb_cmd_addr  out  AW  command byte address
- icb_cmd_read  out  1  constant 1
- icb_rsp_valid  in  1  response valid
- icb_rsp_ready  out  1  constant 1
- icb_rsp_err  in  1  response error
- icb_rsp_rdata  in  DW  response data
- out_valid  out  1  stream word valid
- out_ready  in  1  stream consumer ready
- out_data  out  DW  stream word, in address order

## Operation
- States: IDLE, ISSUE, DRAIN, FIN.
- IDLE: on start, latch the aligned address and word_cnt into a remaining-issue counter, clear err, and go to ISSUE. If word_cnt==0, go to FIN instead.
- ISSUE: drive icb_cmd_valid when credit = outstanding + fifo_count < OUTS.
  - Each cmd handshake increments the address by DW/8, wrapping modulo 2^AW, and decrements the remaining count.
  - After the last handshake, go to DRAIN.
- DRAIN: wait until outstanding==0 and the FIFO is empty, then go to FIN.
- FIN: assert done for one cycle, then return to IDLE.
- Responses: icb_rsp_ready is always 1.
  - Each rsp handshake decrements outstanding and pushes rdata into the FIFO. Error responses are pushed too.
  - Each rsp handshake ORs icb_rsp_err into err.
  - A cmd handshake and an rsp handshake in the same cycle leave outstanding unchanged. This is legal for zero-latency targets.
  - An rsp arriving with outstanding==0 and no concurrent cmd handshake is a protocol violation. It is not pushed.
- Stream: out_valid means the FIFO is not empty. A pop happens on out_valid & out_ready. Push and pop in the same cycle are allowed, including at full and at empty.
- start while busy is ignored.
- Reset mid-transfer: all state clears immediately and the FIFO empties. Responses arriving after reset release are ignored as unsolicited.

## Timing
- Reset values:
  - 0: busy, done, err, icb_cmd_valid, icb_cmd_addr, out_valid, out_data
  - 1: icb_rsp_ready, icb_cmd_read
- start at cycle N leads to busy=1 and icb_cmd_valid=1 at N+1.
- With a zero-latency target and out_ready=1: first out_valid at N+2, then one word per cycle.
- icb_cmd_valid, once asserted, stays asserted with a stable address until cmd_ready. The credit check is done only before asserting cmd_valid.
- The done cycle is the last cycle with busy=1; busy=0 on the next cycle.
- word_cnt==0: done at N+1, busy high only at N+1, no ICB traffic.

## Configuration
- N101_BURST_RD_ERR_ABORT_EN defined:
  - The first rsp error stops new commands and forces ISSUE to DRAIN.
  - Outstanding responses are still accepted and forwarded.
  - done follows with err=1.
- Not defined: all word_cnt commands are always issued; err is only flagged.

## Structure
- Package n101_icb_rd_pkg holds:
  - the state encodings (IDLE=0, ISSUE=1, DRAIN=2, FIN=3)
  - the WORD_BYTES = DW/8 constant and its log2
- One sub-module, n101_icb_rd_fifo:
  - synchronous FIFO with parameters DW and DEPTH=OUTS
  - ports: push/pop/full/empty/count
  - same async active-high reset

## Test plan
- start_addr=0x104, word_cnt=4, zero-latency ROM model, out_ready=1 → addresses 0x104, 0x108, 0x10C, 0x110; four words in order; done 6 cycles after start; err=0.
- start_addr=0xFF8, word_cnt=4, AW=12 → addresses 0xFF8, 0xFFC, 0x000, 0x004.
- out_ready held 0, word_cnt=8 → exactly OUTS=2 commands issued, then cmd_valid stays 0. Releasing out_ready lets all 8 words drain with no loss; icb_rsp_ready never drops.
- Target with 3-cycle rsp latency and cmd_ready toggling every other cycle → outstanding never exceeds 2; data matches the address sequence.
- rsp_err on word 2 of 5:
  - with the macro: ≤ 3+outstanding words delivered, then done with err=1
  - without the macro: 5 words delivered, then done with err=1
- Reset asserted mid-ISSUE with 2 outstanding → all outputs return to reset values at once. After release, a new start with word_cnt=1 completes normally.
